cpu_memory: RTL and testbench
=============================

Name: cpu_memory

Overview:
- Memory stage of the mox125 pipeline; consumes the execute stage's results and control bits.
- Performs load/store accesses on the Wishbone data bus and stalls upstream while a bus access is outstanding.
- Forwards register results, write indices and write enables to the register-file write ports, one cycle after the instruction completes.

Parameters:
- ADDR_WIDTH, 32, data-bus address width.
- DATA_WIDTH, 32, data-bus data width; only 32 is supported.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- pipeline_control_bits_i  in  PCB_WIDTH  control bits from execute (PCB_WA, PCB_WB, PCB_RM, PCB_WM).
- register0_write_index_i  in  4  write index for port A.
- register1_write_index_i  in  4  write index for port B.
- reg0_result_i  in  32  port-A result from execute.
- reg1_result_i  in  32  port-B result from execute.
- memory_address_i  in  32  byte address for load/store.
- mem_result_i  in  32  store data, right-justified.
- mem_size_i  in  2  access size: 00 byte, 01 short, 10 long, 11 treated as long.
- stall_o  out  1  combinational; upstream holds all inputs while high.
- dwb_adr_o  out  ADDR_WIDTH  bus address; bits [1:0] forced to 0.
- dwb_dat_o  out  32  bus write data.
- dwb_dat_i  in  32  bus read data.
- dwb_sel_o  out  4  byte-lane selects.
- dwb_we_o  out  1  write strobe qualifier.
- dwb_cyc_o  out  1  bus cycle.
- dwb_stb_o  out  1  bus strobe.
- dwb_ack_i  in  1  bus acknowledge.
- register_wea_o  out  1  one-cycle port-A write enable.
- register_web_o  out  1  one-cycle port-B write enable.
- register0_write_index_o  out  4  port-A index.
- register1_write_index_o  out  4  port-B index.
- reg0_result_o  out  32  port-A data.
- reg1_result_o  out  32  port-B data.

Behaviour:
- Reset, asynchronous and immediate:
  - state IDLE.
  - All bus outputs 0, including cyc/stb abandoned mid-transfer.
  - wea/web 0; indices and results 0.
  - No writeback occurs for an access aborted by reset.
- mem_op = PCB_RM | PCB_WM. If both are set, this is an illegal combination and is treated as a read.
- stall_o = (IDLE & mem_op) | (BUS_WAIT & !dwb_ack_i).
- IDLE, mem_op=0:
  - At the clock edge, register pass-through: wea/web <= PCB_WA/PCB_WB, and indices/results <= inputs.
  - Latency is one cycle.
- IDLE, mem_op=1:
  - wea/web <= 0.
  - Latch indices, reg0/reg1 results, size and address[1:0].
  - Drive cyc=stb=1, we=PCB_WM, adr, sel and dat.
  - Go to BUS_WAIT.
- BUS_WAIT, ack=0: hold all bus outputs stable; wea/web <= 0.
- BUS_WAIT, ack=1:
  - Drop cyc/stb/we to 0 at the edge; go to IDLE.
  - wea/web <= latched PCB_WA/PCB_WB for exactly one cycle.
  - On a read, reg0_result_o <= extracted load data; reg1_result_o stays the latched value (the POP pointer update).
  - On a write, reg0_result_o stays the latched value.
- Minimum memory-op latency with zero-wait ack: stb high in cycle N+1, ack in N+1, writeback visible in N+2.
- Byte lanes, big-endian (lane 3 = dat[31:24] = lowest address):
  - byte: sel = 4'b1000 >> a[1:0]; dat_o = {4{d[7:0]}}.
  - short: sel = a[1] ? 0011 : 1100; dat_o = {2{d[15:0]}}; a[0] ignored.
  - long: sel = 1111; dat_o = d; a[1:0] ignored.
- Load extraction: selected lanes are right-justified and zero-extended to 32 bits. Sign extension is done elsewhere (SEX ops).
- Back-to-back memory ops: the ack edge returns to IDLE, so the next instruction's request launches in the following cycle. There is a one-cycle bubble with cyc low.
- An ack arriving while in IDLE is ignored.

Decomposition:
- defines.h already carries PCB_WIDTH and the PCB_* bit indices.
- Add to defines.h:
  - MEM_SIZE_B/S/L encodings.
  - Memory-stage state encodings STATE_MEM_IDLE and STATE_MEM_WAIT.
- One natural combinational sub-module: cpu_mem_lanes, holding the sel/dat_o generation and load extraction from size and address[1:0].

Test Plan:
- Reset asserted during BUS_WAIT with stb=1 -> cyc/stb/sel go to 0 immediately without a clock; no wea pulse follows after reset release.
- Non-memory op: PCB_WA=1, idx0=3, reg0=0x1234 -> next cycle wea=1, idx0=3, reg0_result_o=0x1234; stall_o never high.
- Byte load from addr 0x1002, ack after 2 wait cycles, dwb_dat_i=0xAABBCCDD:
  - sel=0010 and adr=0x1000.
  - stall_o high for 3 cycles.
  - Then wea=1 and reg0_result_o=0x000000CC.
- Short store of 0x0000BEEF to 0x2002 -> sel=0011, dat_o=0xBEEFBEEF, we=1; wea/web stay 0.
- POP: RM=1, WA=1, WB=1, long load from 0x3000, reg1_result_i=0x2FFC, dat_i=0x55 -> same-cycle wea=web=1, reg0_result_o=0x55, reg1_result_o=0x2FFC.
- Two back-to-back long stores with zero-wait ack -> two stb pulses separated by exactly one idle cycle; upstream holds inputs while stall_o=1.

Source files
------------

// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the mox125 memory stage: pipeline control bit positions,
// access size encodings and memory-stage state encodings.
package cpu_memory_pkg;

    localparam int unsigned PCB_WIDTH = 4;
    localparam int unsigned PCB_WA    = 0;
    localparam int unsigned PCB_WB    = 1;
    localparam int unsigned PCB_RM    = 2;
    localparam int unsigned PCB_WM    = 3;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_S = 2'b01;
    localparam logic [1:0] MEM_SIZE_L = 2'b10;

    localparam logic STATE_MEM_IDLE = 1'b0;
    localparam logic STATE_MEM_WAIT = 1'b1;

    typedef enum logic {
        StMemIdle = STATE_MEM_IDLE,
        StMemWait = STATE_MEM_WAIT
    } mem_state_e;

    function automatic logic is_mem_op(logic [PCB_WIDTH-1:0] pcb);
        return pcb[PCB_RM] | pcb[PCB_WM];
    endfunction

endpackage

// File: rtl/cpu_memory_if.sv
// Wishbone data-bus bundle between the memory stage (master) and the data memory (slave).
interface cpu_memory_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] dwb_adr_o;
    logic [DATA_WIDTH-1:0] dwb_dat_o;
    logic [DATA_WIDTH-1:0] dwb_dat_i;
    logic [3:0]            dwb_sel_o;
    logic                  dwb_we_o;
    logic                  dwb_cyc_o;
    logic                  dwb_stb_o;
    logic                  dwb_ack_i;

    modport master (
        output dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_cyc_o, dwb_stb_o,
        input  dwb_dat_i, dwb_ack_i
    );

    modport slave (
        input  dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_cyc_o, dwb_stb_o,
        output dwb_dat_i, dwb_ack_i
    );
endinterface

// File: rtl/cpu_mem_lanes.sv
// Big-endian byte-lane steering: store replication, lane selects and
// right-justified, zero-extended load extraction.
module cpu_mem_lanes
    import cpu_memory_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    always_comb begin
        sel       = 4'b1111;
        bus_wdata = store_data;
        load_data = bus_rdata;
        case (size)
            MEM_SIZE_B: begin
                sel       = 4'b1000 >> a_lo;
                bus_wdata = {4{store_data[7:0]}};
                // Lane 3 (dat[31:24]) holds the lowest byte address.
                case (a_lo)
                    2'd0:    load_data = {24'd0, bus_rdata[31:24]};
                    2'd1:    load_data = {24'd0, bus_rdata[23:16]};
                    2'd2:    load_data = {24'd0, bus_rdata[15:8]};
                    default: load_data = {24'd0, bus_rdata[7:0]};
                endcase
            end
            MEM_SIZE_S: begin
                sel       = a_lo[1] ? 4'b0011 : 4'b1100;
                bus_wdata = {2{store_data[15:0]}};
                load_data = a_lo[1] ? {16'd0, bus_rdata[15:0]} : {16'd0, bus_rdata[31:16]};
            end
            default: begin
                sel       = 4'b1111;
                bus_wdata = store_data;
                load_data = bus_rdata;
            end
        endcase
    end

endmodule

// File: rtl/cpu_memory.sv
// mox125 memory stage: runs load/store cycles on the Wishbone data bus, stalls upstream
// while a cycle is outstanding, and registers results toward the register-file write ports.
module cpu_memory
    import cpu_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
    input  logic [3:0]           register0_write_index_i,
    input  logic [3:0]           register1_write_index_i,
    input  logic [31:0]          reg0_result_i,
    input  logic [31:0]          reg1_result_i,
    input  logic [31:0]          memory_address_i,
    input  logic [31:0]          mem_result_i,
    input  logic [1:0]           mem_size_i,
    output logic                 stall_o,
    cpu_memory_if.master         dwb,
    output logic                 register_wea_o,
    output logic                 register_web_o,
    output logic [3:0]           register0_write_index_o,
    output logic [3:0]           register1_write_index_o,
    output logic [31:0]          reg0_result_o,
    output logic [31:0]          reg1_result_o
);

    mem_state_e state_q, state_d;

    logic       wa_q, wa_d, wb_q, wb_d, rd_q, rd_d;
    logic [1:0] size_q, size_d, a_lo_q, a_lo_d;

    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic        wea_q, wea_d, web_q, web_d;
    logic [3:0]  idx0_q, idx0_d, idx1_q, idx1_d;
    logic [31:0] res0_q, res0_d, res1_q, res1_d;

    logic        mem_op;
    logic        is_write;
    logic [1:0]  lane_size;
    logic [1:0]  lane_a_lo;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign mem_op   = is_mem_op(pipeline_control_bits_i);
    // RM together with WM is illegal and resolves to a read.
    assign is_write = pipeline_control_bits_i[PCB_WM] & ~pipeline_control_bits_i[PCB_RM];

    // Idle steers the store path from live inputs; wait steers load extraction from the latch.
    assign lane_size = (state_q == StMemIdle) ? mem_size_i : size_q;
    assign lane_a_lo = (state_q == StMemIdle) ? memory_address_i[1:0] : a_lo_q;

    cpu_mem_lanes u_lanes (
        .size       (lane_size),
        .a_lo       (lane_a_lo),
        .store_data (mem_result_i),
        .bus_rdata  (dwb.dwb_dat_i),
        .sel        (lane_sel),
        .bus_wdata  (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        rd_d    = rd_q;
        size_d  = size_q;
        a_lo_d  = a_lo_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        wea_d   = 1'b0;
        web_d   = 1'b0;
        idx0_d  = idx0_q;
        idx1_d  = idx1_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        stall_o = 1'b0;

        case (state_q)
            StMemIdle: begin
                idx0_d = register0_write_index_i;
                idx1_d = register1_write_index_i;
                res0_d = reg0_result_i;
                res1_d = reg1_result_i;
                if (mem_op) begin
                    stall_o = 1'b1;
                    wa_d    = pipeline_control_bits_i[PCB_WA];
                    wb_d    = pipeline_control_bits_i[PCB_WB];
                    rd_d    = pipeline_control_bits_i[PCB_RM];
                    size_d  = mem_size_i;
                    a_lo_d  = memory_address_i[1:0];
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = is_write;
                    adr_d   = {memory_address_i[ADDR_WIDTH-1:2], 2'b00};
                    sel_d   = lane_sel;
                    dat_d   = lane_wdata;
                    state_d = StMemWait;
                end else begin
                    wea_d = pipeline_control_bits_i[PCB_WA];
                    web_d = pipeline_control_bits_i[PCB_WB];
                end
            end
            StMemWait: begin
                if (!dwb.dwb_ack_i) begin
                    stall_o = 1'b1;
                end else begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    wea_d   = wa_q;
                    web_d   = wb_q;
                    // Port B keeps the latched value so POP can update its pointer.
                    if (rd_q) begin
                        res0_d = lane_load;
                    end
                    state_d = StMemIdle;
                end
            end
            default: state_d = StMemIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StMemIdle;
            wa_q    <= 1'b0;
            wb_q    <= 1'b0;
            rd_q    <= 1'b0;
            size_q  <= 2'b00;
            a_lo_q  <= 2'b00;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= 4'b0000;
            dat_q   <= '0;
            wea_q   <= 1'b0;
            web_q   <= 1'b0;
            idx0_q  <= 4'd0;
            idx1_q  <= 4'd0;
            res0_q  <= 32'd0;
            res1_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            size_q  <= size_d;
            a_lo_q  <= a_lo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            wea_q   <= wea_d;
            web_q   <= web_d;
            idx0_q  <= idx0_d;
            idx1_q  <= idx1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
        end
    end

    assign dwb.dwb_adr_o = adr_q;
    assign dwb.dwb_dat_o = dat_q;
    assign dwb.dwb_sel_o = sel_q;
    assign dwb.dwb_we_o  = we_q;
    assign dwb.dwb_cyc_o = cyc_q;
    assign dwb.dwb_stb_o = stb_q;

    assign register_wea_o          = wea_q;
    assign register_web_o          = web_q;
    assign register0_write_index_o = idx0_q;
    assign register1_write_index_o = idx1_q;
    assign reg0_result_o           = res0_q;
    assign reg1_result_o           = res1_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Self-checking bench for cpu_memory: a per-cycle schedule of stimulus and expected
// outputs is built from instruction-level rules, then replayed against the DUT.
module tb_cpu_memory;
    import cpu_memory_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [PCB_WIDTH-1:0] pcb;
    logic [3:0]  idx0_i, idx1_i;
    logic [31:0] r0_i, r1_i, addr_i, md_i;
    logic [1:0]  sz_i;
    logic        stall;
    logic        wea, web;
    logic [3:0]  idx0_o, idx1_o;
    logic [31:0] r0_o, r1_o;

    cpu_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dwb ();

    cpu_memory dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .pipeline_control_bits_i (pcb),
        .register0_write_index_i (idx0_i),
        .register1_write_index_i (idx1_i),
        .reg0_result_i           (r0_i),
        .reg1_result_i           (r1_i),
        .memory_address_i        (addr_i),
        .mem_result_i            (md_i),
        .mem_size_i              (sz_i),
        .stall_o                 (stall),
        .dwb                     (dwb),
        .register_wea_o          (wea),
        .register_web_o          (web),
        .register0_write_index_o (idx0_o),
        .register1_write_index_o (idx1_o),
        .reg0_result_o           (r0_o),
        .reg1_result_o           (r1_o)
    );

    typedef struct {
        logic [3:0]  pcb;
        logic [3:0]  i0, i1;
        logic [31:0] r0, r1, addr, md, dati;
        logic [1:0]  sz;
        logic        ack;
    } stim_t;

    typedef struct {
        logic        stall, cyc, we, wea, web;
        logic [31:0] adr, dato;
        logic [3:0]  sel, i0, i1;
        logic [31:0] r0, r1;
    } expv_t;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
    } lit_t;

    stim_t stim_q[$];
    expv_t exp_q[$];
    lit_t  lit_q[$];

    // Register-file port values visible to the DUT's consumer in the cycle being scheduled.
    logic        m_wea, m_web;
    logic [3:0]  m_i0, m_i1;
    logic [31:0] m_r0, m_r1;

    int vectors = 0;
    int miscompares = 0;
    int cur = 0;
    logic active = 1'b0;

    function automatic logic [3:0] exp_sel(logic [1:0] sz, logic [1:0] a);
        if (sz == 2'd0) return 4'd8 >> a;
        if (sz == 2'd1) return a[1] ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_dat(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(logic [1:0] sz, logic [1:0] a, logic [31:0] x);
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * (3 - int'(a));
            return (x >> sh) & 32'hFF;
        end
        if (sz == 2'd1) return (x >> (a[1] ? 0 : 16)) & 32'hFFFF;
        return x;
    endfunction

    function automatic logic [31:0] act_field(int fld);
        case (fld)
            0:       return {31'd0, wea};
            1:       return {28'd0, idx0_o};
            2:       return r0_o;
            3:       return {28'd0, dwb.dwb_sel_o};
            4:       return dwb.dwb_adr_o;
            5:       return dwb.dwb_dat_o;
            6:       return {31'd0, dwb.dwb_we_o};
            7:       return r1_o;
            8:       return {31'd0, web};
            9:       return {31'd0, dwb.dwb_cyc_o};
            default: return {31'd0, stall};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic push_cycle(input stim_t s, input logic st, input logic busy, input logic we,
                              input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dato);
        expv_t e;
        e.stall = st;  e.cyc = busy; e.we = busy & we;
        e.adr = adr;   e.sel = sel;  e.dato = dato;
        e.wea = m_wea; e.web = m_web; e.i0 = m_i0; e.i1 = m_i1; e.r0 = m_r0; e.r1 = m_r1;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Schedule one instruction; w = wait cycles before the slave acks a memory op.
    task automatic sched(input stim_t s, input int w, output int start);
        stim_t t;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        we;
        start = stim_q.size();
        t = s;
        t.ack  = ($urandom_range(0, 3) == 0);
        t.dati = $urandom;
        if (!(s.pcb[PCB_RM] | s.pcb[PCB_WM])) begin
            push_cycle(t, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
            m_wea = s.pcb[PCB_WA]; m_web = s.pcb[PCB_WB];
            m_i0 = s.i0; m_i1 = s.i1; m_r0 = s.r0; m_r1 = s.r1;
        end else begin
            push_cycle(t, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
            m_wea = 1'b0; m_web = 1'b0;
            m_i0 = s.i0; m_i1 = s.i1; m_r0 = s.r0; m_r1 = s.r1;
            adr = {s.addr[31:2], 2'b00};
            sel = exp_sel(s.sz, s.addr[1:0]);
            dat = exp_dat(s.sz, s.md);
            we  = s.pcb[PCB_WM] & ~s.pcb[PCB_RM];
            for (int k = 0; k <= w; k++) begin
                t = s;
                t.ack  = (k == w);
                t.dati = (k == w) ? s.dati : $urandom;
                push_cycle(t, (k < w), 1'b1, we, adr, sel, dat);
            end
            m_wea = s.pcb[PCB_WA]; m_web = s.pcb[PCB_WB];
            if (s.pcb[PCB_RM]) m_r0 = exp_load(s.sz, s.addr[1:0], s.dati);
        end
    endtask

    task automatic lit(input int c, input int fld, input logic [31:0] val);
        lit_t l;
        l.cyc = c; l.fld = fld; l.val = val;
        lit_q.push_back(l);
    endtask

    task automatic apply(input stim_t s);
        pcb = s.pcb; idx0_i = s.i0; idx1_i = s.i1; r0_i = s.r0; r1_i = s.r1;
        addr_i = s.addr; md_i = s.md; sz_i = s.sz;
        dwb.dwb_ack_i = s.ack; dwb.dwb_dat_i = s.dati;
    endtask

    always @(negedge clk) begin
        if (active) begin
            expv_t e;
            e = exp_q[cur];
            check("stall", {31'd0, stall}, {31'd0, e.stall});
            check("cyc", {31'd0, dwb.dwb_cyc_o}, {31'd0, e.cyc});
            check("stb", {31'd0, dwb.dwb_stb_o}, {31'd0, e.cyc});
            check("we", {31'd0, dwb.dwb_we_o}, {31'd0, e.we});
            if (e.cyc) begin
                check("adr", dwb.dwb_adr_o, e.adr);
                check("sel", {28'd0, dwb.dwb_sel_o}, {28'd0, e.sel});
                check("dat_o", dwb.dwb_dat_o, e.dato);
            end
            check("wea", {31'd0, wea}, {31'd0, e.wea});
            check("web", {31'd0, web}, {31'd0, e.web});
            check("idx0", {28'd0, idx0_o}, {28'd0, e.i0});
            check("idx1", {28'd0, idx1_o}, {28'd0, e.i1});
            check("res0", r0_o, e.r0);
            check("res1", r1_o, e.r1);
            foreach (lit_q[j]) begin
                if (lit_q[j].cyc == cur) check("literal", act_field(lit_q[j].fld), lit_q[j].val);
            end
        end
    end

    initial begin
        stim_t d, z;
        int s0, s1, s2, s3, s4, s5, sx, w;
        logic [1:0] rw;

        z = '{pcb: 4'd0, i0: 4'd0, i1: 4'd0, r0: 32'd0, r1: 32'd0, addr: 32'd0, md: 32'd0,
              dati: 32'd0, sz: 2'd0, ack: 1'b0};
        rst = 1'b1;
        apply(z);
        m_wea = 1'b0; m_web = 1'b0; m_i0 = 4'd0; m_i1 = 4'd0; m_r0 = 32'd0; m_r1 = 32'd0;

        d = z; d.pcb = 4'b0001; d.i0 = 4'd3; d.r0 = 32'h1234;
        sched(d, 0, s0);
        lit(s0 + 1, 0, 32'd1); lit(s0 + 1, 1, 32'd3); lit(s0 + 1, 2, 32'h1234);
        lit(s0, 10, 32'd0);

        d = z; d.pcb = 4'b0101; d.i0 = 4'd5; d.addr = 32'h1002; d.sz = 2'd0;
        d.dati = 32'hAABBCCDD;
        sched(d, 2, s1);
        lit(s1 + 1, 3, 32'h2); lit(s1 + 1, 4, 32'h1000);
        lit(s1, 10, 32'd1); lit(s1 + 1, 10, 32'd1); lit(s1 + 2, 10, 32'd1);
        lit(s1 + 3, 10, 32'd0);
        lit(s1 + 4, 0, 32'd1); lit(s1 + 4, 2, 32'hCC);

        d = z; d.pcb = 4'b1000; d.addr = 32'h2002; d.md = 32'h0000BEEF; d.sz = 2'd1;
        sched(d, 0, s2);
        lit(s2 + 1, 3, 32'h3); lit(s2 + 1, 5, 32'hBEEFBEEF); lit(s2 + 1, 6, 32'd1);
        lit(s2 + 2, 0, 32'd0); lit(s2 + 2, 8, 32'd0);

        d = z; d.pcb = 4'b0111; d.i0 = 4'd1; d.i1 = 4'd14; d.addr = 32'h3000; d.sz = 2'd2;
        d.r0 = 32'h3000; d.r1 = 32'h2FFC; d.dati = 32'h55;
        sched(d, 0, s3);
        lit(s3 + 2, 0, 32'd1); lit(s3 + 2, 8, 32'd1);
        lit(s3 + 2, 2, 32'h55); lit(s3 + 2, 7, 32'h2FFC);

        d = z; d.pcb = 4'b1000; d.sz = 2'd2; d.addr = 32'h4000; d.md = 32'h11111111;
        sched(d, 0, s4);
        d.addr = 32'h4004; d.md = 32'h22222222;
        sched(d, 0, s5);
        lit(s4 + 1, 9, 32'd1); lit(s4 + 2, 9, 32'd0); lit(s4 + 3, 9, 32'd1);
        lit(s4 + 3, 4, 32'h4004); lit(s4 + 3, 5, 32'h22222222);

        for (int n = 0; n < 250; n++) begin
            d.pcb = 4'($urandom_range(0, 3));
            d.i0 = 4'($urandom); d.i1 = 4'($urandom);
            d.r0 = $urandom; d.r1 = $urandom; d.addr = $urandom; d.md = $urandom;
            d.dati = $urandom; d.sz = 2'($urandom); d.ack = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                rw = 2'($urandom_range(1, 3));
                d.pcb[PCB_RM] = rw[0];
                d.pcb[PCB_WM] = rw[1];
            end
            w = $urandom_range(0, 3);
            sched(d, w, sx);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cyc", {31'd0, dwb.dwb_cyc_o}, 32'd0);
        check("reset_wea", {31'd0, wea}, 32'd0);
        check("reset_res0", r0_o, 32'd0);
        check("reset_adr", dwb.dwb_adr_o, 32'd0);
        rst = 1'b0;

        for (int c = 0; c < stim_q.size(); c++) begin
            @(posedge clk);
            #1;
            apply(stim_q[c]);
            cur = c;
            active = 1'b1;
        end
        @(posedge clk);
        #1;
        active = 1'b0;

        // Abort an outstanding load with reset: bus drops at once and no writeback follows.
        apply(z);
        @(posedge clk);
        #1;
        d = z; d.pcb = 4'b0101; d.addr = 32'h5000; d.sz = 2'd2;
        apply(d);
        @(posedge clk);
        #1;
        check("abort_pre_cyc", {31'd0, dwb.dwb_cyc_o}, 32'd1);
        check("abort_pre_stall", {31'd0, stall}, 32'd1);
        #1;
        rst = 1'b1;
        apply(z);
        #1;
        check("abort_cyc", {31'd0, dwb.dwb_cyc_o}, 32'd0);
        check("abort_stb", {31'd0, dwb.dwb_stb_o}, 32'd0);
        check("abort_sel", {28'd0, dwb.dwb_sel_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dwb.dwb_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_wea", {31'd0, wea}, 32'd0);
            check("abort_cyc_after", {31'd0, dwb.dwb_cyc_o}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
